// File: rtl/hm01b0_capture_ctrl.sv
// hm01b0_capture_ctrl
//   Captures one frame from the HM01B0 parallel pixel bus into an external
//   frame RAM. The camera bus is asynchronous to clock, so it is sampled through
//   a 2-flop chain. pixclk gets a third flop so its rising edge can be found.
//   After an arm request the controller throws away any frame that is already
//   in progress. It then waits for a clean vsync rise and crops a fixed
//   COL_START/ROW_START/WIN_W/WIN_H window. Each pixel inside the window becomes
//   one RAM write with a linear address.
//
// Ports
//   clock         system clock (osc_12m)
//   reset         asynchronous, active-high reset
//   cam_pixdata   camera pixel byte (async)
//   cam_pixclk    camera pixel clock (async, at most clock/4)
//   cam_hsync     camera line-valid (async)
//   cam_vsync     camera frame-valid (async)
//   arm           single-cycle request to capture the next full frame
//   abort         cancel capture and return to IDLE
//   busy          high in every state except IDLE
//   done          one-cycle pulse when a captured frame has ended
//   wr_en         one-cycle RAM write strobe
//   wr_addr       RAM write address
//   wr_data       RAM write data
//   frame_pixels  number of writes in the last completed capture
//   err_short     last capture wrote fewer than WIN_W*WIN_H pixels
//
// Write interface: wr_en/wr_addr/wr_data is a fire-and-forget strobe. It has no
// ready/backpressure. The RAM must accept one write in any cycle in which
// wr_en is high, and wr_addr/wr_data are valid only in that cycle.

module hm01b0_capture_ctrl #(
    parameter int COL_START = 2,
    parameter int ROW_START = 2,
    parameter int WIN_W     = 320,
    parameter int WIN_H     = 320,
    parameter int ADDR_W    = 17
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        cam_pixdata,
    input  logic              cam_pixclk,
    input  logic              cam_hsync,
    input  logic              cam_vsync,
    input  logic              arm,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] frame_pixels,
    output logic              err_short
);

    localparam logic [10:0]       COL_LO    = 11'(COL_START);
    localparam logic [10:0]       COL_HI    = 11'(COL_START + WIN_W);
    localparam logic [9:0]        ROW_LO    = 10'(ROW_START);
    localparam logic [9:0]        ROW_HI    = 10'(ROW_START + WIN_H);
    localparam logic [ADDR_W-1:0] PIX_TOTAL = ADDR_W'(WIN_W * WIN_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Synchronizer chain. Every bus signal shares the same two stages, so
    // hsync_s, vsync_s and data_s stay aligned with pix_edge. The s3 stages
    // hold the previous s2 value, which is used for edge detection.
    logic       pixclk_s1, pixclk_s2, pixclk_s3;
    logic       hsync_s1, hsync_s2, hsync_s3;
    logic       vsync_s1, vsync_s2, vsync_s3;
    logic [7:0] data_s1, data_s2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixclk_s1 <= 1'b0;
            pixclk_s2 <= 1'b0;
            pixclk_s3 <= 1'b0;
            hsync_s1  <= 1'b0;
            hsync_s2  <= 1'b0;
            hsync_s3  <= 1'b0;
            vsync_s1  <= 1'b0;
            vsync_s2  <= 1'b0;
            vsync_s3  <= 1'b0;
            data_s1   <= 8'd0;
            data_s2   <= 8'd0;
        end else begin
            pixclk_s1 <= cam_pixclk;
            pixclk_s2 <= pixclk_s1;
            pixclk_s3 <= pixclk_s2;
            hsync_s1  <= cam_hsync;
            hsync_s2  <= hsync_s1;
            hsync_s3  <= hsync_s2;
            vsync_s1  <= cam_vsync;
            vsync_s2  <= vsync_s1;
            vsync_s3  <= vsync_s2;
            data_s1   <= cam_pixdata;
            data_s2   <= data_s1;
        end
    end

    logic       pix_edge, hsync_s, vsync_s;
    logic [7:0] data_s;

    assign pix_edge = pixclk_s2 & ~pixclk_s3;
    assign hsync_s  = hsync_s2;
    assign vsync_s  = vsync_s2;
    assign data_s   = data_s2;

    // FSM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (arm)                  state_nxt = S_WAIT_LOW;
            S_WAIT_LOW:  if (!vsync_s)             state_nxt = S_WAIT_HIGH;
            S_WAIT_HIGH: if (vsync_s)              state_nxt = S_CAPTURE;
            S_CAPTURE:   if (!vsync_s && vsync_s3) state_nxt = S_DONE;
            S_DONE:                                state_nxt = S_IDLE;
            default:                               state_nxt = S_IDLE;
        endcase
        // Abort overrides everything, including an arm in the same cycle.
        if (abort) state_nxt = S_IDLE;
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE) && !abort;

    // Window counters
    logic [10:0]       col;
    logic [9:0]        row;
    // addr doubles as the write count: it advances exactly once per write.
    logic [ADDR_W-1:0] addr;

    logic start_capture, pix_ok, hsync_fall, in_window, do_write;

    assign start_capture = (state == S_WAIT_HIGH) && vsync_s && !abort;
    // A pixel counts only while both line-valid and frame-valid are high.
    // Pixels are dropped in the cycle abort is seen, so no strobe leaks into IDLE.
    assign pix_ok     = (state == S_CAPTURE) && pix_edge && hsync_s && vsync_s && !abort;
    assign hsync_fall = (state == S_CAPTURE) && !hsync_s && hsync_s3;
    assign in_window  = (row >= ROW_LO) && (row < ROW_HI) &&
                        (col >= COL_LO) && (col < COL_HI) &&
                        (addr < PIX_TOTAL);
    assign do_write   = pix_ok && in_window;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (start_capture) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else begin
            // pix_ok needs hsync_s high and hsync_fall needs it low, so at
            // most one of these two branches fires in a given cycle.
            if (pix_ok && (col != 11'h7FF)) col <= col + 11'd1;
            if (hsync_fall) begin
                if (col != '0) row <= row + 10'd1;
                col <= '0;
            end
            if (do_write) addr <= addr + 1'b1;
        end
    end

    // Registered write strobe and frame result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= 8'd0;
            frame_pixels <= '0;
            err_short    <= 1'b0;
        end else begin
            wr_en <= do_write;
            if (do_write) begin
                wr_addr <= addr;
                wr_data <= data_s;
            end
            if ((state == S_DONE) && !abort) begin
                frame_pixels <= addr;
                err_short    <= (addr < PIX_TOTAL);
            end
        end
    end

endmodule

// File: tb/tb_hm01b0_capture_ctrl.sv
// tb_hm01b0_capture_ctrl
//   Directed bench for hm01b0_capture_ctrl, configured for a 4x3 window at
//   (2,2). A simple camera model drives the bus at clock/4 from the falling
//   clock edge. Each in-window pixel pushes {addr, data} onto exp_q when it is
//   driven, and the write monitor pops and compares entries as wr_en appears.

module tb_hm01b0_capture_ctrl;

    localparam int ADDR_W    = 17;
    localparam int COL_START = 2;
    localparam int ROW_START = 2;
    localparam int WIN_W     = 4;
    localparam int WIN_H     = 3;
    localparam int W         = ADDR_W + 8;

    logic              clock;
    logic              reset;
    logic [7:0]        cam_pixdata;
    logic              cam_pixclk;
    logic              cam_hsync;
    logic              cam_vsync;
    logic              arm;
    logic              abort;
    logic              busy;
    logic              done;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] frame_pixels;
    logic              err_short;

    hm01b0_capture_ctrl #(
        .COL_START(COL_START),
        .ROW_START(ROW_START),
        .WIN_W    (WIN_W),
        .WIN_H    (WIN_H),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cam_pixdata (cam_pixdata),
        .cam_pixclk  (cam_pixclk),
        .cam_hsync   (cam_hsync),
        .cam_vsync   (cam_vsync),
        .arm         (arm),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_pixels(frame_pixels),
        .err_short   (err_short)
    );

    // Clock / reset / watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard
    int compared   = 0;
    int mismatched = 0;
    int done_cnt   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;

    // Camera model state
    bit m_active;
    int m_row;
    int m_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (done) done_cnt++;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr_en", 32'(wr_en), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(mon_e[W-1:8]));
                check("wr_data", 32'(wr_data), 32'(mon_e[7:0]));
            end
        end
    end

    // Driver tasks
    task automatic outputs_zero(input string ph);
        check({ph, "_busy"},         32'(busy),         32'd0);
        check({ph, "_done"},         32'(done),         32'd0);
        check({ph, "_wr_en"},        32'(wr_en),        32'd0);
        check({ph, "_wr_addr"},      32'(wr_addr),      32'd0);
        check({ph, "_wr_data"},      32'(wr_data),      32'd0);
        check({ph, "_frame_pixels"}, 32'(frame_pixels), 32'd0);
        check({ph, "_err_short"},    32'(err_short),    32'd0);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clock);
        arm = 1'b0;
    endtask

    task automatic frame_begin(input bit capt);
        m_active  = capt;
        m_row     = 0;
        m_addr    = 0;
        cam_vsync = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    task automatic frame_end();
        repeat (4) @(negedge clock);
        cam_vsync = 1'b0;
    endtask

    // One line of ncols pixels. With glitch set, one extra pixclk rise is
    // issued in the same cycle that hsync drops. That pixel must be ignored.
    task automatic send_row(input int ncols, input bit glitch);
        logic [7:0] d;
        cam_hsync   = 1'b1;
        cam_pixdata = 8'd0;
        repeat (2) @(negedge clock);
        for (int c = 0; c < ncols; c++) begin
            d = 8'($urandom_range(0, 255));
            cam_pixdata = d;
            if (m_active && m_row >= ROW_START && m_row < ROW_START + WIN_H &&
                c >= COL_START && c < COL_START + WIN_W && m_addr < WIN_W * WIN_H) begin
                exp_q.push_back({17'(m_addr), d});
                m_addr++;
            end
            repeat (2) @(negedge clock);
            cam_pixclk = 1'b1;
            repeat (2) @(negedge clock);
            cam_pixclk = 1'b0;
        end
        repeat (2) @(negedge clock);
        if (glitch) begin
            cam_pixdata = 8'($urandom_range(0, 255));
            cam_pixclk  = 1'b1;
            cam_hsync   = 1'b0;
            repeat (2) @(negedge clock);
            cam_pixclk  = 1'b0;
        end else begin
            cam_hsync = 1'b0;
        end
        m_row++;
        repeat (4) @(negedge clock);
    endtask

    task automatic wait_done(input string ph, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({ph, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clock);
        check({ph, "_done_one_cycle"}, 32'(done), 32'd0);
        check({ph, "_busy_after"},     32'(busy), 32'd0);
    endtask

    task automatic frame_result(input string ph, input int exp_pix, input bit exp_err);
        check({ph, "_frame_pixels"}, 32'(frame_pixels), 32'(exp_pix));
        check({ph, "_err_short"},    32'(err_short),    32'(exp_err));
        check({ph, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Directed sequence
    initial begin
        int done_before;
        reset       = 1'b1;
        arm         = 1'b0;
        abort       = 1'b0;
        cam_pixdata = 8'd0;
        cam_pixclk  = 1'b0;
        cam_hsync   = 1'b0;
        cam_vsync   = 1'b0;

        // 1: reset with a random bus, then idle without arm
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            cam_pixdata = 8'($urandom_range(0, 255));
            cam_pixclk  = 1'($urandom_range(0, 1));
            cam_hsync   = 1'($urandom_range(0, 1));
            cam_vsync   = 1'($urandom_range(0, 1));
        end
        outputs_zero("reset");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            cam_pixdata = 8'($urandom_range(0, 255));
            cam_pixclk  = 1'($urandom_range(0, 1));
            cam_hsync   = 1'($urandom_range(0, 1));
            cam_vsync   = 1'($urandom_range(0, 1));
        end
        cam_pixclk = 1'b0;
        cam_hsync  = 1'b0;
        cam_vsync  = 1'b0;
        repeat (5) @(negedge clock);
        outputs_zero("no_arm");

        // 2: arm mid-frame; the partial frame is dropped and the next one captured
        frame_begin(1'b0);
        send_row(8, 1'b0);
        send_row(8, 1'b0);
        pulse_arm();
        check("arm_busy", 32'(busy), 32'd1);
        for (int r = 0; r < 4; r++) send_row(8, 1'b0);
        frame_end();
        repeat (10) @(negedge clock);
        frame_begin(1'b1);
        for (int r = 0; r < 6; r++) send_row(8, 1'b0);
        frame_end();
        wait_done("full", 40);
        frame_result("full", 12, 1'b0);

        // 3: frame truncated after two window rows
        pulse_arm();
        repeat (4) @(negedge clock);
        frame_begin(1'b1);
        for (int r = 0; r < 4; r++) send_row(8, 1'b0);
        frame_end();
        wait_done("short", 40);
        frame_result("short", 8, 1'b1);

        // 4: long lines and extra rows; writes stop at the window edge
        pulse_arm();
        repeat (4) @(negedge clock);
        frame_begin(1'b1);
        for (int r = 0; r < 9; r++) send_row(12, 1'b0);
        frame_end();
        wait_done("long", 40);
        frame_result("long", 12, 1'b0);

        // 5: abort during capture, then re-arm
        pulse_arm();
        repeat (4) @(negedge clock);
        frame_begin(1'b1);
        for (int r = 0; r < 3; r++) send_row(8, 1'b0);
        repeat (6) @(negedge clock);
        done_before = done_cnt;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        m_active = 1'b0;
        for (int r = 0; r < 3; r++) send_row(8, 1'b0);
        frame_end();
        repeat (20) @(negedge clock);
        check("abort_no_done", 32'(done_cnt), 32'(done_before));
        frame_result("abort", 12, 1'b0);
        pulse_arm();
        repeat (4) @(negedge clock);
        frame_begin(1'b1);
        for (int r = 0; r < 6; r++) send_row(8, 1'b0);
        frame_end();
        wait_done("rearm", 40);
        frame_result("rearm", 12, 1'b0);

        // 6: pixclk rise coincident with hsync fall is ignored, row advances once
        pulse_arm();
        repeat (4) @(negedge clock);
        frame_begin(1'b1);
        for (int r = 0; r < 6; r++) send_row(5, 1'b1);
        frame_end();
        wait_done("glitch", 40);
        frame_result("glitch", 9, 1'b1);

        repeat (10) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
